// File: rtl/ahb_lite_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : ahb_lite_mem_slave
// Purpose  : AHB-Lite single-port SRAM slave. Supports byte, halfword, word
//            and (DW=64) doubleword transfers with little-endian byte lanes,
//            a programmable number of wait states per OKAY data phase, and
//            a two-cycle ERROR response for bad accesses or a forced error.
// Ports    : hclk, hresetn       - clock, asynchronous active-low reset
//            hsel, haddr, htrans - address-phase select/address/type
//            hwrite, hsize       - direction and transfer size
//            hburst, hprot       - accepted but have no effect
//            hwdata              - write data (data phase)
//            error               - force ERROR on the transfer sampled now
//            hrdata, hready, hresp - read data, ready, response
// Revision : 1.0 - initial release
// ============================================================================
module ahb_lite_mem_slave #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int RW          = 1,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic          hclk,
    input  logic          hresetn,
    input  logic          hsel,
    input  logic [AW-1:0] haddr,
    input  logic [1:0]    htrans,
    input  logic          hwrite,
    input  logic [2:0]    hsize,
    input  logic [2:0]    hburst,
    input  logic [3:0]    hprot,
    input  logic [DW-1:0] hwdata,
    input  logic          error,
    output logic [DW-1:0] hrdata,
    output logic          hready,
    output logic [RW-1:0] hresp
);

    localparam int          c_LANES = DW / 8;
    localparam int          c_LB    = $clog2(c_LANES);
    localparam int          c_IW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0]  c_WAIT  = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;
    logic              r_pend;      // an OKAY data phase is outstanding
    logic              w_pend_nxt;
    logic [c_IW-1:0]   r_idx;
    logic [c_LB-1:0]   r_lane;
    logic [2:0]        r_size;
    logic              r_write;

    logic [DW-1:0]     r_mem [MEM_DEPTH];

    logic [AW-1:0]     w_word;
    logic [2:0]        w_align_mask;
    logic              w_bad;
    logic              w_accept;
    logic              w_complete;
    logic [c_LANES-1:0] w_be;
    logic              w_unused;

    assign w_unused = ^{hburst, hprot, htrans[0]};

    // ------------------------------------------------------------------
    // Address-phase decode
    // ------------------------------------------------------------------
    assign w_word = haddr >> c_LB;

    always_comb begin
        w_align_mask = 3'b000;
        case (hsize)
            3'd0:    w_align_mask = 3'b000;
            3'd1:    w_align_mask = 3'b001;
            3'd2:    w_align_mask = 3'b011;
            default: w_align_mask = 3'b111;
        endcase
    end

    assign w_bad = (w_word >= AW'(MEM_DEPTH))
                 | (hsize > 3'(c_LB))
                 | (|(haddr[2:0] & w_align_mask));

    assign hready   = (r_state == ST_IDLE) || (r_state == ST_ERR2);
    assign w_accept = hsel & hready & htrans[1];

    // A pending OKAY transfer completes in the first cycle it sits in IDLE.
    assign w_complete = (r_state == ST_IDLE) & r_pend;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pend_nxt  = r_pend;
        case (r_state)
            ST_IDLE, ST_ERR2: begin
                w_state_nxt = ST_IDLE;
                w_pend_nxt  = 1'b0;
                if (w_accept) begin
                    if (error | w_bad) begin
                        w_state_nxt = ST_ERR1;
                    end else begin
                        w_pend_nxt = 1'b1;
                        if (c_WAIT != 4'd0) begin
                            w_state_nxt = ST_WAIT;
                            w_cnt_nxt   = c_WAIT;
                        end
                    end
                end
            end
            ST_WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ERR1: w_state_nxt = ST_ERR2;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Captured address-phase attributes
    // ------------------------------------------------------------------
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_idx   <= '0;
            r_lane  <= '0;
            r_size  <= 3'd0;
            r_write <= 1'b0;
        end else if (w_accept) begin
            r_idx   <= w_word[c_IW-1:0];
            r_lane  <= haddr[c_LB-1:0];
            r_size  <= hsize;
            r_write <= hwrite;
        end
    end

    // ------------------------------------------------------------------
    // Byte lanes and memory
    // ------------------------------------------------------------------
    always_comb begin
        w_be = '0;
        for (int i = 0; i < c_LANES; i++) begin
            if ((i >= int'(r_lane)) && (i < int'(r_lane) + (1 << r_size))) begin
                w_be[i] = 1'b1;
            end
        end
    end

    // The array has no reset; a transfer cut by reset is dropped because
    // r_pend is cleared asynchronously.
    always_ff @(posedge hclk) begin
        if (w_complete && r_write) begin
            for (int i = 0; i < c_LANES; i++) begin
                if (w_be[i]) begin
                    r_mem[r_idx][8*i +: 8] <= hwdata[8*i +: 8];
                end
            end
        end
    end

    // The array is read combinationally in the completing cycle, so a write
    // that finished at the preceding edge is already visible: a read whose
    // address phase overlapped that write's data phase gets the new data.
    assign hrdata = (w_complete && !r_write) ? r_mem[r_idx] : '0;
    assign hresp  = RW'((r_state == ST_ERR1) || (r_state == ST_ERR2));

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_lite_mem_slave
// Purpose  : Self-checking bench for ahb_lite_mem_slave. Two instances
//            (0 and 3 wait states) share one bus; a reference memory model
//            predicts every cycle's hready/hresp/hrdata.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_lite_mem_slave;

    typedef struct {
        bit        vld;
        bit [31:0] addr;
        bit        wr;
        bit [2:0]  size;
        bit [31:0] wdata;
        bit        err;
    } txn_t;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        hsel, hwrite, error, sel;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic        hsel0, hsel1;
    logic [31:0] hrdata0, hrdata1;
    logic        hready0, hready1;
    logic [0:0]  hresp0, hresp1;
    logic [31:0] m_hrdata;
    logic        m_hready;
    logic [0:0]  m_hresp;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] ref_mem [2][256];
    txn_t        q[$];

    always #5 hclk = ~hclk;

    assign hsel0    = hsel & ~sel;
    assign hsel1    = hsel & sel;
    assign m_hready = sel ? hready1 : hready0;
    assign m_hresp  = sel ? hresp1  : hresp0;
    assign m_hrdata = sel ? hrdata1 : hrdata0;

    ahb_lite_mem_slave #(.AW(32), .DW(32), .RW(1), .MEM_DEPTH(256), .WAIT_STATES(0)) u_dut0 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
        .error(error), .hrdata(hrdata0), .hready(hready0), .hresp(hresp0));

    ahb_lite_mem_slave #(.AW(32), .DW(32), .RW(1), .MEM_DEPTH(256), .WAIT_STATES(3)) u_dut1 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel1), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
        .error(error), .hrdata(hrdata1), .hready(hready1), .hresp(hresp1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic bit is_bad(input txn_t t);
        return ((t.addr >> 2) >= 32'd256) || (t.size > 3'd2) ||
               ((t.addr & ((32'd1 << t.size) - 32'd1)) != 32'd0);
    endfunction

    task automatic push(input bit wr, input bit [31:0] addr, input bit [2:0] size,
                        input bit [31:0] wdata, input bit err);
        txn_t t;
        t.vld = 1'b1; t.addr = addr; t.wr = wr; t.size = size; t.wdata = wdata; t.err = err;
        q.push_back(t);
    endtask

    task automatic model_write(input int m, input txn_t t);
        int idx;
        int lo;
        idx = int'(t.addr >> 2);
        lo  = int'(t.addr[1:0]);
        for (int b = lo; b < lo + (1 << t.size); b++)
            ref_mem[m][idx][8*b +: 8] = t.wdata[8*b +: 8];
    endtask

    task automatic drive_idle();
        hsel = 1'b0; htrans = 2'd0; haddr = 32'd0; hwrite = 1'b0;
        hsize = 3'd0; error = 1'b0; hburst = 3'd0; hprot = 4'd0;
    endtask

    task automatic drive_addr(input txn_t a, input bit rdy);
        hburst = 3'($urandom); hprot = 4'($urandom);
        if (!rdy) begin
            // master garbage while stalled: must be ignored
            hsel = 1'($urandom); htrans = 2'($urandom); haddr = $urandom;
            hwrite = 1'($urandom); hsize = 3'($urandom); error = 1'($urandom);
        end else if (a.vld) begin
            hsel = 1'b1; htrans = 2'($urandom_range(2, 3)); haddr = a.addr;
            hwrite = a.wr; hsize = a.size; error = a.err;
        end else begin
            if ($urandom_range(0, 1) == 0) begin
                hsel = 1'b0; htrans = 2'($urandom);
            end else begin
                hsel = 1'b1; htrans = 2'($urandom_range(0, 1));
            end
            haddr = $urandom; hwrite = 1'($urandom); hsize = 3'($urandom);
            error = 1'($urandom);
        end
    endtask

    // Pipelined master: runs every queued transfer on the selected instance
    // and checks each cycle of each data phase against the model.
    task automatic run_seq();
        txn_t        a, d;
        int          k, ws, m;
        bit          rdy, e_rdy, e_resp;
        logic [31:0] e_rd;
        ws = sel ? 3 : 0;
        m  = sel ? 1 : 0;
        d.vld = 1'b0;
        a.vld = 1'b0;
        if (q.size() > 0) a = q.pop_front();
        k = 0;
        while (q.size() > 0 || a.vld || d.vld) begin
            @(negedge hclk);
            rdy = m_hready;
            e_rd = 32'd0;
            if (!d.vld) begin
                e_rdy = 1'b1; e_resp = 1'b0;
            end else if (d.err || is_bad(d)) begin
                e_rdy = (k == 1); e_resp = 1'b1;
            end else begin
                e_rdy = (k == ws); e_resp = 1'b0;
                if (k == ws && !d.wr) e_rd = ref_mem[m][d.addr >> 2];
            end
            chk($sformatf("ws%0d hready a=%h k=%0d", ws, d.addr, k), 32'(m_hready), 32'(e_rdy));
            chk($sformatf("ws%0d hresp a=%h k=%0d", ws, d.addr, k), 32'(m_hresp), 32'(e_resp));
            chk($sformatf("ws%0d hrdata a=%h k=%0d", ws, d.addr, k), m_hrdata, e_rd);
            n_cmp++;
            assert (rdy || k < 20) else begin
                n_err++;
                $error("FAIL timeout: hready=%0b after %0d cycles, required 1", rdy, k);
            end
            if (!rdy && k >= 20) rdy = 1'b1;
            drive_addr(a, rdy);
            hwdata = d.vld ? d.wdata : $urandom;
            @(posedge hclk);
            if (rdy) begin
                if (d.vld && !d.err && !is_bad(d) && d.wr) model_write(m, d);
                d = a;
                k = 0;
                a.vld = 1'b0;
                if (q.size() > 0) a = q.pop_front();
            end else begin
                k++;
            end
        end
        @(negedge hclk);
        drive_idle();
    endtask

    task automatic push_random(input int n);
        bit [31:0] ad;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                txn_t t;
                t.vld = 1'b0; t.addr = 0; t.wr = 0; t.size = 0; t.wdata = 0; t.err = 0;
                q.push_back(t);
            end else begin
                ad = ($urandom_range(0, 9) == 0) ? 32'h400 + 32'($urandom_range(0, 63))
                                                 : 32'($urandom_range(0, 63));
                push(1'($urandom), ad, 3'($urandom_range(0, 3)), $urandom,
                     ($urandom_range(0, 7) == 0));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old;
        sel = 1'b0; hresetn = 1'b0; hwdata = 32'd0;
        drive_idle();

        // Reset with the bus idle.
        repeat (3) begin
            @(negedge hclk);
            chk("rst hready0", 32'(hready0), 32'd1);
            chk("rst hresp0",  32'(hresp0),  32'd0);
            chk("rst hrdata0", hrdata0,      32'd0);
            chk("rst hready1", 32'(hready1), 32'd1);
            chk("rst hresp1",  32'(hresp1),  32'd0);
            chk("rst hrdata1", hrdata1,      32'd0);
        end
        hresetn = 1'b1;

        // Preload the words used by later reads in both instances.
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            for (int w = 0; w < 16; w++) push(1'b1, 32'(w * 4), 3'd2, $urandom, 1'b0);
            run_seq();
        end

        // Zero wait states: back-to-back write/read, byte and half lanes.
        sel = 1'b0;
        push(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 1'b0);
        push(1'b0, 32'h10, 3'd2, 32'h0, 1'b0);
        push(1'b1, 32'h10, 3'd2, 32'h11223344, 1'b0);
        push(1'b1, 32'h13, 3'd0, 32'hAA000000, 1'b0);
        push(1'b0, 32'h10, 3'd2, 32'h0, 1'b0);
        push(1'b1, 32'h12, 3'd1, 32'h55660000, 1'b0);
        push(1'b0, 32'h10, 3'd2, 32'h0, 1'b0);
        // Error cases followed by readback.
        push(1'b1, 32'h02, 3'd2, 32'hCAFEF00D, 1'b0);
        push(1'b0, 32'h00, 3'd2, 32'h0, 1'b0);
        push(1'b1, 32'h400, 3'd2, 32'h12345678, 1'b0);
        push(1'b1, 32'h08, 3'd2, 32'h87654321, 1'b1);
        push(1'b0, 32'h08, 3'd2, 32'h0, 1'b0);
        push(1'b0, 32'h04, 3'd3, 32'h0, 1'b0);
        run_seq();

        push_random(80);
        run_seq();

        // Three wait states.
        sel = 1'b1;
        push(1'b0, 32'h04, 3'd2, 32'h0, 1'b0);
        push(1'b1, 32'h02, 3'd2, 32'h0BADBAD0, 1'b0);
        push(1'b0, 32'h00, 3'd2, 32'h0, 1'b0);
        run_seq();
        push_random(50);
        run_seq();

        // Reset in the middle of a write's wait states.
        old = ref_mem[1][8];
        @(negedge hclk);
        chk("rstw idle hready", 32'(hready1), 32'd1);
        hsel = 1'b1; htrans = 2'd2; haddr = 32'h20; hwrite = 1'b1; hsize = 3'd2; error = 1'b0;
        @(negedge hclk);
        chk("rstw wait hready", 32'(hready1), 32'd0);
        drive_idle();
        hwdata = ~old;
        @(posedge hclk);
        #2 hresetn = 1'b0;
        #1;
        chk("rstw async hready", 32'(hready1), 32'd1);
        chk("rstw async hresp",  32'(hresp1),  32'd0);
        chk("rstw async hrdata", hrdata1,      32'd0);
        repeat (2) @(negedge hclk);
        hresetn = 1'b1;
        push(1'b0, 32'h20, 3'd2, 32'h0, 1'b0);
        run_seq();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
